// File: rtl/adder_vector_checker.sv
// Hardware stimulus/response checker: walks all eight {a,b,c} vectors into two adder DUTs and counts wrong sums.
// Optional macro ADDER_CHECK_HALT_ON_ERROR_EN ends the run at the first mismatching vector.
module adder_vector_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int LOOPS         = 1,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       y_structural,
    input  logic [1:0]       y_other,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             mismatch,
    output logic [ERR_W-1:0] err_count,
    output logic [2:0]       fail_vec,
    output logic             fail_valid
);

    typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, SAMPLE, DONE} state_t;
    typedef logic [ERR_W+1:0] err_wide_t;

    localparam logic [3:0]       SETTLE_LOAD = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;
    localparam logic [7:0]       LAST_LOOP   = 8'(LOOPS - 1);
    localparam logic [ERR_W-1:0] ERR_MAX     = '1;

    state_t           state, state_next;
    logic [2:0]       index;
    logic [7:0]       loop_cnt;
    logic [3:0]       settle_cnt;
    logic [1:0]       expected;
    logic             wrong_s, wrong_o, any_wrong, halt_now;
    err_wide_t        err_sum;
    logic [ERR_W-1:0] err_next;

    // Compare against the registered a/b/c, so the y inputs only ever reach flops.
    always_comb begin
        expected  = 2'(a) + 2'(b) + 2'(c);
        wrong_s   = (y_structural != expected);
        wrong_o   = (y_other != expected);
        any_wrong = wrong_s || wrong_o;
        err_sum   = err_wide_t'(err_count) + err_wide_t'(wrong_s) + err_wide_t'(wrong_o);
        err_next  = (err_sum > err_wide_t'(ERR_MAX)) ? ERR_MAX : err_sum[ERR_W-1:0];
`ifdef ADDER_CHECK_HALT_ON_ERROR_EN
        halt_now  = any_wrong;
`else
        halt_now  = 1'b0;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: defaulting state_next first keeps this block free of inferred latches.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: if (start) state_next = DRIVE;
            DRIVE:      state_next = (SETTLE_CYCLES > 0) ? SETTLE : SAMPLE;
            SETTLE:     if (settle_cnt == 4'd0) state_next = SAMPLE;
            SAMPLE: begin
                if (halt_now)                state_next = DONE;
                else if (index != 3'd7)      state_next = DRIVE;
                else if (loop_cnt < LAST_LOOP) state_next = DRIVE;
                else                         state_next = DONE;
            end
            default:    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            {a, b, c}  <= 3'b000;
            mismatch   <= 1'b0;
            err_count  <= '0;
            fail_vec   <= 3'b000;
            fail_valid <= 1'b0;
            index      <= 3'd0;
            loop_cnt   <= 8'd0;
            settle_cnt <= 4'd0;
        end else begin
            mismatch <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        err_count  <= '0;
                        fail_vec   <= 3'b000;
                        fail_valid <= 1'b0;
                        index      <= 3'd0;
                        loop_cnt   <= 8'd0;
                    end
                end
                DRIVE: begin
                    {a, b, c}  <= index;
                    settle_cnt <= SETTLE_LOAD;
                end
                SETTLE: begin
                    if (settle_cnt != 4'd0) settle_cnt <= settle_cnt - 4'd1;
                end
                SAMPLE: begin
                    mismatch  <= any_wrong;
                    err_count <= err_next;
                    if (any_wrong && !fail_valid) begin
                        fail_vec   <= {a, b, c};
                        fail_valid <= 1'b1;
                    end
                    // Index wraps 7->0 on its own; the loop counter advances on that wrap.
                    if (state_next == DRIVE) begin
                        index <= index + 3'd1;
                        if (index == 3'd7) loop_cnt <= loop_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy = (state == DRIVE) || (state == SETTLE) || (state == SAMPLE);
        done = (state == DONE);
        pass = done && (err_count == '0);
    end

endmodule

// File: tb/tb_adder_vector_checker.sv
// Scoreboard bench for adder_vector_checker: stimulus pushes expected mismatch vectors and end-of-run
// results into queues; a negedge monitor pops and compares them as the DUT reports.
module tb_adder_vector_checker;

    logic clk = 1'b0;
    logic reset, start1, start2;
    int   mode;
    logic sel;

    always #5 clk = ~clk;

    logic       a1, b1, c1, busy1, done1, pass1, mm1, fv1;
    logic [7:0] err1;
    logic [2:0] fvec1;
    logic [1:0] ys1, yo1;
    logic       a2, b2, c2, busy2, done2, pass2, mm2, fv2;
    logic [2:0] err2;
    logic [2:0] fvec2;
    logic [1:0] ys2, yo2;

    // DUT models: returns {y_structural, y_other} for a fault mode and vector.
    function automatic logic [3:0] model(input int m, input logic [2:0] v);
        logic [1:0] sum;
        logic [1:0] par;
        sum = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
        par = {1'b0, ^v};
        case (m)
            1:       return {sum, 2'b00};
            2:       return {par, par};
            3:       return {~sum, ~sum};
            4:       return {((v == 3'b100) ? (sum ^ 2'b01) : sum), sum};
            default: return {sum, sum};
        endcase
    endfunction

    assign {ys1, yo1} = model(mode, {a1, b1, c1});
    assign {ys2, yo2} = model(mode, {a2, b2, c2});

    adder_vector_checker #(.SETTLE_CYCLES(2), .LOOPS(1), .ERR_W(8)) dut (
        .clk(clk), .reset(reset), .start(start1), .y_structural(ys1), .y_other(yo1),
        .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1), .pass(pass1), .mismatch(mm1),
        .err_count(err1), .fail_vec(fvec1), .fail_valid(fv1)
    );

    adder_vector_checker #(.SETTLE_CYCLES(2), .LOOPS(2), .ERR_W(3)) dut_sat (
        .clk(clk), .reset(reset), .start(start2), .y_structural(ys2), .y_other(yo2),
        .a(a2), .b(b2), .c(c2), .busy(busy2), .done(done2), .pass(pass2), .mismatch(mm2),
        .err_count(err2), .fail_vec(fvec2), .fail_valid(fv2)
    );

    typedef struct {
        logic [7:0] err;
        logic [2:0] fvec;
        logic       fvalid;
        logic       pass;
        logic [2:0] abc;
        int         cycles;
    } done_exp_t;

    done_exp_t  done_q[$];
    logic [2:0] mm_q[$];
    int total = 0;
    int bad   = 0;
    int done_count = 0;
    int busy_cycles = 0;
    logic done_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the selected DUT pulses mismatch or enters DONE.
    always @(negedge clk) begin
        logic [2:0] abc;
        logic       c_busy, c_done, c_pass, c_mm, c_fv;
        logic [7:0] c_err;
        logic [2:0] c_fvec;
        done_exp_t  e;
        if (sel) begin
            abc = {a2, b2, c2}; c_busy = busy2; c_done = done2; c_pass = pass2;
            c_mm = mm2; c_fv = fv2; c_err = {5'b0, err2}; c_fvec = fvec2;
        end else begin
            abc = {a1, b1, c1}; c_busy = busy1; c_done = done1; c_pass = pass1;
            c_mm = mm1; c_fv = fv1; c_err = err1; c_fvec = fvec1;
        end
        if (reset) busy_cycles = 0;
        else if (c_busy) busy_cycles++;
        if (c_mm) begin
            if (mm_q.size() == 0) begin
                total++; bad++;
                $display("FAIL mismatch_unexpected: got pulse on vector %0h expected none", abc);
            end else begin
                check("mismatch_vec", abc, mm_q.pop_front());
            end
        end
        if (c_done && !done_prev) begin
            if (done_q.size() == 0) begin
                total++; bad++;
                $display("FAIL done_unexpected: got done expected none");
            end else begin
                e = done_q.pop_front();
                check("err_count", c_err, e.err);
                check("fail_vec", c_fvec, e.fvec);
                check("fail_valid", c_fv, e.fvalid);
                check("pass", c_pass, e.pass);
                check("abc_final", abc, e.abc);
                check("run_cycles", busy_cycles, e.cycles);
                check("mismatch_left", mm_q.size(), 0);
            end
            busy_cycles = 0;
            done_count++;
        end
        done_prev = c_done;
    end

    task automatic pulse_start(input logic s);
        @(negedge clk);
        if (s) start2 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic run(input logic s, input int m, input logic [7:0] err, input logic [2:0] fvec,
                       input logic fvalid, input logic pss, input logic [2:0] abc, input int cyc,
                       input bit mid_starts);
        int d0;
        int n;
        sel  = s;
        mode = m;
        done_q.push_back('{err, fvec, fvalid, pss, abc, cyc});
        d0 = done_count;
        pulse_start(s);
        if (mid_starts) begin
            repeat (5) @(negedge clk);
            pulse_start(s);
            repeat (9) @(negedge clk);
            pulse_start(s);
        end
        n = 0;
        while (done_count == d0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (done_count == d0) begin
            total++; bad++;
            $display("FAIL done_timeout: got no done in %0d cycles expected done", n);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; start1 = 1'b0; start2 = 1'b0; mode = 0; sel = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_abc", {a1, b1, c1}, 3'b000);
        check("rst_busy", busy1, 1'b0);
        check("rst_done", done1, 1'b0);
        check("rst_pass", pass1, 1'b0);
        check("rst_mismatch", mm1, 1'b0);
        check("rst_err", err1, 8'd0);
        check("rst_fail_vec", fvec1, 3'b000);
        check("rst_fail_valid", fv1, 1'b0);
        check("rst_err_sat", err2, 3'd0);
        reset = 1'b0;
        @(negedge clk);

        // Correct adders: no mismatches, pass after 32 cycles.
        run(1'b0, 0, 8'd0, 3'b000, 1'b0, 1'b1, 3'b111, 32, 1'b0);

`ifdef ADDER_CHECK_HALT_ON_ERROR_EN
        mm_q.push_back(3'b001);
        run(1'b0, 1, 8'd1, 3'b001, 1'b1, 1'b0, 3'b001, 8, 1'b0);
        mm_q.push_back(3'b011);
        run(1'b0, 2, 8'd2, 3'b011, 1'b1, 1'b0, 3'b011, 16, 1'b0);
        run(1'b0, 4, 8'd1, 3'b100, 1'b1, 1'b0, 3'b100, 20, 1'b0);
        mm_q.pop_back();
        mm_q.push_back(3'b100);
`else
        // y_other stuck at 0: wrong on every vector with a nonzero sum.
        for (int v = 1; v < 8; v++) mm_q.push_back(3'(v));
        run(1'b0, 1, 8'd7, 3'b001, 1'b1, 1'b0, 3'b111, 32, 1'b0);
        // Parity-only adders: wrong where the sum is 2 or 3, both outputs each time.
        mm_q.push_back(3'b011); mm_q.push_back(3'b101);
        mm_q.push_back(3'b110); mm_q.push_back(3'b111);
        run(1'b0, 2, 8'd8, 3'b011, 1'b1, 1'b0, 3'b111, 32, 1'b0);
        mm_q.push_back(3'b100);
        run(1'b0, 4, 8'd1, 3'b100, 1'b1, 1'b0, 3'b111, 32, 1'b0);
`endif
        // The halt build pushes 100 after the run above; keep the queue consistent for both builds.
        if (mm_q.size() != 0) begin
`ifdef ADDER_CHECK_HALT_ON_ERROR_EN
            mm_q.delete();
`endif
        end

        // Reset during SETTLE of vector 101 aborts the run.
        sel = 1'b0;
`ifdef ADDER_CHECK_HALT_ON_ERROR_EN
        mode = 0;
`else
        mode = 1;
        for (int v = 1; v < 5; v++) mm_q.push_back(3'(v));
`endif
        pulse_start(1'b0);
        repeat (21) @(negedge clk);
        check("abc_before_reset", {a1, b1, c1}, 3'b101);
        check("busy_before_reset", busy1, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_abc", {a1, b1, c1}, 3'b000);
        check("abort_busy", busy1, 1'b0);
        check("abort_done", done1, 1'b0);
        check("abort_err", err1, 8'd0);
        check("abort_fail_valid", fv1, 1'b0);
        check("abort_mismatch", mm1, 1'b0);
        check("abort_mm_left", mm_q.size(), 0);
        mm_q.delete();
        reset = 1'b0;
        @(negedge clk);
        // Clean run afterwards, with start pulses mid-run that must not change its length.
        run(1'b0, 0, 8'd0, 3'b000, 1'b0, 1'b1, 3'b111, 32, 1'b1);

        // 3-bit counter, both outputs always wrong, two loops: saturates at 7.
`ifdef ADDER_CHECK_HALT_ON_ERROR_EN
        mm_q.push_back(3'b000);
        run(1'b1, 3, 8'd2, 3'b000, 1'b1, 1'b0, 3'b000, 4, 1'b0);
`else
        for (int l = 0; l < 2; l++)
            for (int v = 0; v < 8; v++) mm_q.push_back(3'(v));
        run(1'b1, 3, 8'd7, 3'b000, 1'b1, 1'b0, 3'b111, 64, 1'b0);
`endif
        check("sat_done_hold", done2, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adder_vector_checker.md
Name: adder_vector_checker

Overview:
- Synthesisable stimulus/response engine for the 3-input, 2-bit-output adder interface: drives a, b, c into two adder implementations (structural and alternative) and checks both y outputs against a+b+c.
- Sits on the driving and checking side of the adder interface, opposite the adder DUTs, so the exhaustive check runs on hardware without a simulator bench.
- Walks all 8 input vectors, counts mismatches, and reports pass/fail plus the first failing vector.

Parameters:
- SETTLE_CYCLES, 2, clock cycles waited after driving a vector before sampling the DUT outputs; legal range 0..15.
- LOOPS, 1, number of complete 8-vector passes per start; legal range 1..255.
- ERR_W, 8, width of the error counter.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a run; sampled only in IDLE or DONE
- y_structural  in  2  output of the structural adder DUT
- y_other  in  2  output of the alternative adder DUT
- a  out  1  DUT input a (vector bit 2)
- b  out  1  DUT input b (vector bit 1)
- c  out  1  DUT input c (vector bit 0)
- busy  out  1  high from the first DRIVE cycle until DONE is entered
- done  out  1  high while in DONE
- pass  out  1  done && err_count==0
- mismatch  out  1  one-cycle pulse in any SAMPLE cycle where either DUT output is wrong
- err_count  out  ERR_W  total mismatches in the current run; saturates at all-ones
- fail_vec  out  3  {a,b,c} of the first mismatching vector; 0 if none
- fail_valid  out  1  set when fail_vec is captured

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: state=IDLE; a=b=c=0, busy=0, done=0, pass=0, mismatch=0, err_count=0, fail_vec=0, fail_valid=0, vector index=0, loop count=0.
- Reset asserted mid-run aborts the run immediately, with the same values as above.
- States: IDLE, DRIVE, SETTLE, SAMPLE, DONE.
- IDLE: start=1 clears err_count, fail_vec and fail_valid, sets index=0 and loop=0, and moves to DRIVE.
- DRIVE (1 cycle): registers {a,b,c}=index. Moves to SETTLE when SETTLE_CYCLES>0, otherwise directly to SAMPLE.
- SETTLE: down-counter runs for exactly SETTLE_CYCLES cycles, then moves to SAMPLE.
- SAMPLE (1 cycle):
  - expected = a+b+c, computed 2-bit zero-extended (range 0..3).
  - Each of y_structural and y_other is compared separately; each wrong output adds 1 to err_count, so +2 if both are wrong in the same cycle.
  - err_count saturates at all-ones, never wraps.
  - mismatch=1 in this cycle if either output is wrong.
  - On the first mismatch of the run: fail_vec={a,b,c}, fail_valid=1. Later mismatches do not overwrite them.
- SAMPLE exit:
  - index<7: index+1, go to DRIVE.
  - index==7 and loop<LOOPS-1: index wraps to 0, loop+1, go to DRIVE.
  - Otherwise: go to DONE.
- Cycles per vector = SETTLE_CYCLES+2. Run length = 8*LOOPS*(SETTLE_CYCLES+2) cycles from the first DRIVE cycle to DONE entry.
- DONE: done=1, a/b/c hold the last vector, results hold. start=1 behaves as in IDLE (clears results, restarts). start during DRIVE, SETTLE or SAMPLE is ignored.
- Outputs a, b, c, mismatch and all status outputs are registered, with no combinational path from the y inputs to any output.

Optional Feature:
- Macro: ADDER_CHECK_HALT_ON_ERROR_EN.
- Defined: the first mismatch goes from SAMPLE straight to DONE. a/b/c keep the failing vector, err_count holds 1 or 2, pass=0.
- Undefined: the run always completes all 8*LOOPS vectors, as described above.

Test Plan:
- Correct DUT models (y=a+b+c), SETTLE_CYCLES=2, LOOPS=1, start pulse → {a,b,c} steps 000..111, one vector every 4 cycles; done after 32 cycles; err_count=0, pass=1, fail_valid=0, mismatch never high.
- y_other stuck at 2'b00, y_structural correct → 7 mismatch pulses; err_count=7, fail_vec=3'b001, pass=0.
- Both DUTs return a^b^c in bit 0 with bit 1=0 → mismatches on vectors 011, 101, 110 and 111 (2 per vector); err_count=8, fail_vec=3'b011.
- ERR_W=3, both outputs always wrong, LOOPS=2 → err_count saturates at 7, no wrap; done after 64 cycles.
- reset asserted during SETTLE of vector 101 → next cycle IDLE with all outputs at reset values; start afterwards runs cleanly from 000. start pulses mid-run are ignored, with the run length unchanged.
- With ADDER_CHECK_HALT_ON_ERROR_EN and y_structural wrong only on 100 → DONE right after that SAMPLE; {a,b,c}=100, err_count=1, fail_vec=100.
